onehot_decoder_pipe: RTL and testbench
======================================

# onehot_decoder_pipe

- Registered 3-to-8 one-hot decoder with a valid/ready handshake on both sides and a two-entry skid buffer.
- Sits downstream of the 8-input priority encoder: consumes its `{out, valid}` result stream and expands each index back to a one-hot grant vector for the request sources.
- Tracks which grant lines have been delivered since the last clear (sticky mask) and counts delivered beats.
- Sustains one beat per cycle under continuous flow.

## Interface

- `IN_W`, default 3: index width. The block is only required to work at the default.
- `OUT_W`, default 8: one-hot width. Must equal `1 << IN_W`.
- `clk` input 1: single clock. All logic is rising-edge triggered.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: acceptance enable. While low, no new beats are accepted. Buffered beats still drain.
- `in_idx` input IN_W: index to decode. Meaningful only when `in_valid` is high.
- `in_valid` input 1: an upstream beat is present.
- `in_ready` output 1: the block can accept a beat this cycle.
- `out_onehot` output OUT_W: decoded vector, equal to `1 << idx`.
- `out_valid` output 1: `out_onehot` holds a beat.
- `out_ready` input 1: the downstream consumer takes the beat.
- `clr_mask` input 1: synchronous clear of `seen_mask` and `beat_count`.
- `seen_mask` output OUT_W: OR of all `out_onehot` values transferred since the last reset or clear.
- `beat_count` output 8: number of output transfers, wrapping modulo 256.

## Operation

- Handshake definitions:
  - Accept: `in_valid & in_ready` at a rising edge.
  - Transfer: `out_valid & out_ready` at a rising edge.
- Storage:
  - Output register: `out_onehot` / `out_valid`.
  - Skid register: one decoded vector plus its valid bit.
- Occupancy FSM states: EMPTY, ONE, TWO.
- `in_ready = en & (state != TWO)`. This is combinational from `en` and registered state only. It must never depend on `in_valid` or `out_ready`.
- `out_valid` is high exactly when state is ONE or TWO.
- EMPTY transitions:
  - Accept: output register loads `1 << in_idx`, go to ONE.
  - Otherwise: stay in EMPTY.
- ONE transitions:
  - Accept and transfer: output register loads the new vector, stay in ONE.
  - Accept without transfer: skid register loads the new vector, go to TWO. The output register holds.
  - Transfer without accept: go to EMPTY. `out_onehot` clears to 0.
  - Neither: hold.
- TWO transitions:
  - No accept is possible, since `in_ready` is 0.
  - Transfer: output register loads the skid vector, skid valid clears, go to ONE.
  - No transfer: hold.
- Ordering: strict FIFO. Beats leave in the order they were accepted. None are dropped or duplicated.
- `out_onehot` is stable while `out_valid & ~out_ready`. It is exactly one-hot whenever `out_valid` is high and all zeros when `out_valid` is low.
- `seen_mask`:
  - On each transfer: `seen_mask <= seen_mask | out_onehot`.
  - `clr_mask` alone: clears to 0.
  - `clr_mask` in the same cycle as a transfer: ends as that transfer's vector only (clear first, then set).
- `beat_count`:
  - Increments by 1 per transfer and wraps 255 -> 0.
  - `clr_mask` with a transfer in the same cycle gives 1.
  - `clr_mask` alone gives 0.
- `en` falling mid-stream:
  - The cycle `en` is low accepts nothing.
  - Contents of the output and skid registers are kept and drain normally.
  - `en` rising resumes acceptance in the same cycle.
- `clr_mask` has no effect on buffered data or the FSM.

## Timing

- Reset (asynchronous assert, synchronous release):
  - State goes to EMPTY.
  - `out_valid`, `out_onehot`, skid contents, `seen_mask` and `beat_count` are all 0.
  - `in_ready` is 0 while `rst_n` is low, and equals `en` from the first cycle after release.
- Reset mid-operation discards all buffered beats. No transfer is reported for them.
- Latency: a beat accepted at edge N is visible on `out_valid` / `out_onehot` after edge N, when state was EMPTY, or ONE with a transfer at N.
- A skid-held beat appears on the output one cycle after the transfer that empties the output register.
- Throughput: one beat per cycle with `out_ready` held high, indefinitely.
- Backpressure: the block absorbs at most two beats after `out_ready` drops.
- `seen_mask` and `beat_count` update at the transfer edge and are visible the following cycle.

## Test plan

- Reset, then `en=1`, drive `in_idx` 0..7 back-to-back with `out_ready=1`:
  - Outputs are 0x01, 0x02, ... 0x80, one per cycle, each one cycle after its accept.
  - `seen_mask=0xFF`, `beat_count=8`.
- Drive idx 3, 5, 6 on consecutive cycles with `out_ready=0`:
  - `in_ready` drops after the second accept, so idx 6 is held upstream.
  - Raising `out_ready` yields 0x08, 0x20, 0x40 in order, with no loss.
- `en=0` with `in_valid=1`, idx 2 for 3 cycles:
  - `in_ready=0`, no output.
  - `en=1` gives 0x04 one cycle later.
- Transfer of idx 4 in the same cycle as `clr_mask`, with prior `seen_mask=0x0F` and `beat_count=10`:
  - Next cycle `seen_mask=0x10`, `beat_count=1`.
- 256 continuous transfers of idx 7:
  - `beat_count` wraps to 0.
  - Then assert `rst_n` low while in state TWO: all outputs are 0 immediately, and no beats appear after release.

Source files
------------

// File: rtl/onehot_decoder_pipe_if.sv
// rtl/onehot_decoder_pipe_if.sv - index-in / one-hot-out stream bundle for onehot_decoder_pipe
//
// Signals:
//   in_idx     upstream index to decode, meaningful while in_valid is high
//   in_valid   upstream beat present
//   in_ready   decoder can take a beat this cycle
//   out_onehot decoded grant vector
//   out_valid  out_onehot holds a beat
//   out_ready  downstream consumer takes the beat
// Modports:
//   master  the testbench/system side that drives indices and consumes grants
//   slave   the decoder side
interface onehot_decoder_pipe_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
);
  logic [IN_W-1:0]  in_idx;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_onehot;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_idx,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_onehot,
    input  out_valid
  );

  modport slave (
    input  in_idx,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_onehot,
    output out_valid
  );
endinterface

// File: rtl/onehot_decoder_pipe.sv
// rtl/onehot_decoder_pipe.sv - registered 3-to-8 one-hot decoder with two-entry skid buffer
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          acceptance enable; buffered beats keep draining while low
//   clr_mask    synchronous clear of seen_mask and beat_count
//   bus         stream bundle (slave side): in_idx/in_valid/in_ready upstream,
//               out_onehot/out_valid/out_ready downstream
//   seen_mask   OR of every grant vector transferred since reset/clear
//   beat_count  number of output transfers, wraps modulo 256
module onehot_decoder_pipe #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr_mask,
  onehot_decoder_pipe_if.slave bus,
  output logic [OUT_W-1:0]     seen_mask,
  output logic [7:0]           beat_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] skid_q, skid_d;
  logic             skid_vld;
  logic [OUT_W-1:0] decoded;
  logic             accept;
  logic             xfer;

  // Gating with rst_n keeps in_ready low throughout reset even though the
  // state register already reads EMPTY while reset is asserted.
  assign bus.in_ready   = en & rst_n & (state_q != TWO);
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_onehot = out_q;

  // The skid entry is occupied exactly when the FSM is in TWO.
  assign skid_vld = (state_q == TWO);

  assign decoded = OUT_W'(1) << bus.in_idx;
  assign accept  = bus.in_valid & bus.in_ready;
  assign xfer    = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = decoded;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          out_d = decoded;
        end else if (accept) begin
          // Output is stalled: park the new beat behind it.
          skid_d  = decoded;
          state_d = TWO;
        end else if (xfer) begin
          out_d   = '0;
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain path exists.
        if (xfer && skid_vld) begin
          out_d   = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
      end
      default: begin
        out_d   = '0;
        skid_d  = '0;
        state_d = EMPTY;
      end
    endcase
  end

  // Clear takes effect before the OR, so a clear coinciding with a transfer
  // leaves only that transfer's vector and a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_mask  <= '0;
      beat_count <= '0;
    end else if (clr_mask) begin
      seen_mask  <= xfer ? out_q : '0;
      beat_count <= xfer ? 8'd1 : 8'd0;
    end else if (xfer) begin
      seen_mask  <= seen_mask | out_q;
      beat_count <= beat_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// tb/tb_onehot_decoder_pipe.sv - directed self-checking bench for onehot_decoder_pipe
module tb_onehot_decoder_pipe;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr_mask;
  logic [7:0] seen_mask;
  logic [7:0] beat_count;

  int n_checks;
  int n_pass;

  onehot_decoder_pipe_if #(.IN_W(3), .OUT_W(8)) bus ();

  onehot_decoder_pipe #(.IN_W(3), .OUT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr_mask   (clr_mask),
    .bus        (bus.slave),
    .seen_mask  (seen_mask),
    .beat_count (beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_tab [8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_tab  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    rst_n         = 1'b0;
    en            = 1'b0;
    clr_mask      = 1'b0;
    bus.in_idx    = 3'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_onehot", 32'(bus.out_onehot), 32'h0);
    check("rst_seen", 32'(seen_mask), 32'h0);
    check("rst_count", 32'(beat_count), 32'h0);
    en = 1'b1;
    #1;
    check("rst_in_ready_low", 32'(bus.in_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Back-to-back indices 0..7 with the consumer always ready
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_idx = 3'(i);
      tick();
      check("stream_valid", 32'(bus.out_valid), 32'h1);
      check("stream_onehot", 32'(bus.out_onehot), 32'(exp_tab[i]));
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_drained", 32'(bus.out_valid), 32'h0);
    check("stream_seen", 32'(seen_mask), 32'hFF);
    check("stream_count", 32'(beat_count), 32'd8);

    // Backpressure: idx 3, 5, 6 with the consumer stalled
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_idx    = 3'd3;
    tick();
    check("bp_first_out", 32'(bus.out_onehot), 32'h08);
    check("bp_ready_one", 32'(bus.in_ready), 32'h1);
    bus.in_idx = 3'd5;
    tick();
    check("bp_ready_two", 32'(bus.in_ready), 32'h0);
    check("bp_hold_out", 32'(bus.out_onehot), 32'h08);
    bus.in_idx = 3'd6;
    tick();
    check("bp_stall_out", 32'(bus.out_onehot), 32'h08);
    check("bp_stall_ready", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_skid_out", 32'(bus.out_onehot), 32'h20);
    check("bp_ready_back", 32'(bus.in_ready), 32'h1);
    tick();
    check("bp_third_out", 32'(bus.out_onehot), 32'h40);
    bus.in_valid = 1'b0;
    tick();
    check("bp_drained", 32'(bus.out_valid), 32'h0);
    check("bp_count", 32'(beat_count), 32'd11);

    // Acceptance disabled while a beat is offered
    en           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_idx   = 3'd2;
    #1;
    check("en_low_ready", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_low_no_out", 32'(bus.out_valid), 32'h0);
    end
    en = 1'b1;
    #1;
    check("en_high_ready", 32'(bus.in_ready), 32'h1);
    tick();
    check("en_resume_out", 32'(bus.out_onehot), 32'h04);
    bus.in_valid = 1'b0;
    tick();
    check("en_count", 32'(beat_count), 32'd12);

    // clr_mask alone
    clr_mask = 1'b1;
    tick();
    clr_mask = 1'b0;
    check("clr_seen", 32'(seen_mask), 32'h0);
    check("clr_count", 32'(beat_count), 32'h0);

    // Build seen_mask=0x0F, beat_count=10, then clear together with idx 4
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_idx = 3'(i % 4);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    check("pre_clr_seen", 32'(seen_mask), 32'h0F);
    check("pre_clr_count", 32'(beat_count), 32'd10);
    bus.in_valid = 1'b1;
    bus.in_idx   = 3'd4;
    tick();
    check("idx4_out", 32'(bus.out_onehot), 32'h10);
    bus.in_valid = 1'b0;
    clr_mask     = 1'b1;
    tick();
    clr_mask = 1'b0;
    check("clr_xfer_seen", 32'(seen_mask), 32'h10);
    check("clr_xfer_count", 32'(beat_count), 32'd1);

    // 256 continuous transfers of idx 7 wrap the counter
    clr_mask = 1'b1;
    tick();
    clr_mask = 1'b0;
    check("wrap_start", 32'(beat_count), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_idx   = 3'd7;
    for (int i = 0; i < 256; i++) begin
      tick();
    end
    check("wrap_255", 32'(beat_count), 32'd255);
    check("wrap_out", 32'(bus.out_onehot), 32'h80);
    bus.in_valid = 1'b0;
    tick();
    check("wrap_zero", 32'(beat_count), 32'd0);
    check("wrap_seen", 32'(seen_mask), 32'h80);

    // Fill both entries, then reset mid-cycle
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_idx    = 3'd1;
    tick();
    bus.in_idx = 3'd2;
    tick();
    check("two_ready", 32'(bus.in_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'h0);
    check("async_rst_onehot", 32'(bus.out_onehot), 32'h0);
    check("async_rst_count", 32'(beat_count), 32'h0);
    check("async_rst_seen", 32'(seen_mask), 32'h0);
    check("async_rst_ready", 32'(bus.in_ready), 32'h0);
    bus.in_valid = 1'b0;
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_beat", 32'(bus.out_valid), 32'h0);
    end
    check("post_rst_count", 32'(beat_count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
